// File: rtl/half_adder.sv
// Half adder: s = a ^ b, c = a & b.
// Ports: a, b (addend bits) -> s (sum bit), c (carry bit).
// Purely combinational leaf cell; no clock, no reset.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder with combinational outputs and a registered stage that
// doubles as the carry state for bit-serial addition.
// Ports: clk, reset (sync, active-high), inp0/inp1 addend bits, cin external
//   carry-in, serial_en selects carry_q as carry-in; sum/carry combinational,
//   sum_q/carry_q registered one cycle late.
module full_adder_1bit (
  input  logic clk,
  input  logic reset,
  input  logic inp0,
  input  logic inp1,
  input  logic cin,
  input  logic serial_en,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);

  logic cin_eff;
  logic ha0_s;
  logic ha0_c;
  logic ha1_c;
  logic sum_d;
  logic carry_d;

  // In serial mode the previous bit's carry feeds this bit.
  assign cin_eff = serial_en ? carry_q : cin;

  half_adder u_ha0 (
    .a (inp0),
    .b (inp1),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (cin_eff),
    .s (sum),
    .c (ha1_c)
  );

  // The two half-adder carries can never both be 1, so OR is exact.
  assign carry = ha0_c | ha1_c;

  always_comb begin
    sum_d   = sum;
    carry_d = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_full_adder_1bit.sv
module tb_full_adder_1bit;

  logic clk;
  logic reset;
  logic inp0;
  logic inp1;
  logic cin;
  logic serial_en;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;

  int checks;
  int passed;

  // Scoreboard of expected {sum_q, carry_q} per clocked step.
  logic [1:0] exp_q[$];
  // Bench-side copy of the serial carry state.
  logic m_cq;

  full_adder_1bit dut (
    .clk       (clk),
    .reset     (reset),
    .inp0      (inp0),
    .inp1      (inp1),
    .cin       (cin),
    .serial_en (serial_en),
    .sum       (sum),
    .carry     (carry),
    .sum_q     (sum_q),
    .carry_q   (carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic add, returns {sum, carry}.
  function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
    logic [1:0] t;
    t = 2'(a) + 2'(b) + 2'(c);
    return {t[0], t[1]};
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clocked step: drive inputs, check combinational outputs, push the
  // expected registered result, clock, then pop and compare.
  task automatic cycle(input string tag, input logic a, input logic b, input logic c,
                       input logic se, input logic rst, output logic [1:0] q);
    logic [1:0] comb_exp;
    logic [1:0] reg_exp;
    logic [1:0] popped;
    inp0 = a; inp1 = b; cin = c; serial_en = se; reset = rst;
    comb_exp = ref_add(a, b, se ? m_cq : c);
    reg_exp  = rst ? 2'b00 : comb_exp;
    #1;
    chk({tag, "_comb"}, {sum, carry}, comb_exp);
    exp_q.push_back(reg_exp);
    m_cq = reg_exp[0];
    @(posedge clk);
    #1;
    q = {sum_q, carry_q};
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      popped = exp_q.pop_front();
      chk({tag, "_reg"}, q, popped);
    end
  endtask

  initial begin
    logic [1:0] tt [8];
    logic [1:0] q;
    logic [3:0] sbits;
    logic [2:0] idx;

    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    checks = 0;
    passed = 0;
    m_cq = 1'b0;

    // Reset held with all addends high: registers clear, combinational stays 1/1.
    cycle("rst0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, q);
    cycle("rst1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, q);
    chk("rst_comb", {sum, carry}, 2'b11);
    // Serial mode during reset: carry-in is the cleared register.
    cycle("rst_ser", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, q);

    // Combinational sweep, reset held so the registers stay cleared.
    serial_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      inp0 = idx[2]; inp1 = idx[1]; cin = idx[0];
      #10;
      chk($sformatf("tt%0d", i), {sum, carry}, tt[i]);
    end
    m_cq = 1'b0;

    // Registered latency.
    cycle("lat0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, q);
    chk("lat0_const", q, 2'b01);
    cycle("lat1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, q);
    chk("lat1_const", q, 2'b10);

    // Serial add 1011 + 0110, LSB first.
    cycle("add0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, q); sbits[0] = q[1];
    cycle("add1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, q); sbits[1] = q[1];
    cycle("add2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, q); sbits[2] = q[1];
    cycle("add3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, q); sbits[3] = q[1];
    chk("add_sum_lo", sbits[1:0], 2'b01);
    chk("add_sum_hi", sbits[3:2], 2'b00);
    chk("add_cout", {1'b0, carry_q}, 2'b01);

    // Serial subtract 0101 - 0011 = 0101 + 1100 + 1.
    cycle("sub0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, q); sbits[0] = q[1];
    cycle("sub1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, q); sbits[1] = q[1];
    cycle("sub2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, q); sbits[2] = q[1];
    cycle("sub3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, q); sbits[3] = q[1];
    chk("sub_diff_lo", sbits[1:0], 2'b10);
    chk("sub_diff_hi", sbits[3:2], 2'b00);
    chk("sub_noborrow", {1'b0, carry_q}, 2'b01);

    // Reset on bit 2 of a serial add: carry state lost.
    cycle("mr0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, q);
    cycle("mr1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, q);
    chk("mr1_carry", {1'b0, carry_q}, 2'b01);
    cycle("mr2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, q);
    chk("mr_cleared", q, 2'b00);
    // Next serial bit 1+0 must see carry-in 0: sum 1, carry 0.
    inp0 = 1'b1; inp1 = 1'b0; cin = 1'b1; serial_en = 1'b1; reset = 1'b0;
    #1;
    chk("mr3_cin0", {sum, carry}, 2'b10);
    cycle("mr3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, q);
    chk("mr3_const", q, 2'b10);

    // serial_en toggle acts combinationally (carry_q is 0 here).
    inp0 = 1'b1; inp1 = 1'b0; cin = 1'b1; serial_en = 1'b0;
    #1;
    chk("tog_ext", {sum, carry}, 2'b01);
    serial_en = 1'b1;
    #1;
    chk("tog_ser", {sum, carry}, 2'b10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
